// File: rtl/conv_layer_mem.sv
// Layer-result memory for the CONV result bus: two banks (layer-0 conv output, layer-1
// max-pool output) serving CONV reads/writes, plus a valid/ready dump of both layers to the
// host once CONV finishes.
module conv_layer_mem #(
  parameter int unsigned DW       = 20,
  parameter int unsigned AW       = 12,
  parameter int unsigned L0_DEPTH = 4096,
  parameter int unsigned L1_DEPTH = 1024,
  parameter logic [2:0]  CSEL_L0  = 3'b001,
  parameter logic [2:0]  CSEL_L1  = 3'b011
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          busy,
  input  logic          cwr,
  input  logic [AW-1:0] caddr_wr,
  input  logic [DW-1:0] cdata_wr,
  input  logic          crd,
  input  logic [AW-1:0] caddr_rd,
  input  logic [2:0]    csel,
  output logic [DW-1:0] cdata_rd,
  output logic          dump_valid,
  input  logic          dump_ready,
  output logic [DW-1:0] dump_data,
  output logic          dump_layer,
  output logic [AW-1:0] dump_addr,
  output logic          dump_last,
  output logic          done
);

  localparam int unsigned L0AW = $clog2(L0_DEPTH);
  localparam int unsigned L1AW = $clog2(L1_DEPTH);
  localparam logic [AW-1:0] L0_LAST = AW'(L0_DEPTH - 1);
  localparam logic [AW-1:0] L1_LAST = AW'(L1_DEPTH - 1);

  typedef enum logic [2:0] {StIdle, StArmed, StDump0, StDump1, StFin} state_e;

  state_e        state_q, state_d;
  logic          wr0_seen_q, wr1_seen_q;
  logic [AW-1:0] iss_addr_q, iss_addr_d;   // next address to load into the output register
  logic          iss_done_q, iss_done_d;   // final word of the whole dump has been loaded

  logic [DW-1:0] l0_mem [L0_DEPTH];
  logic [DW-1:0] l1_mem [L1_DEPTH];

  logic [DW-1:0] cdata_rd_q;
  logic          dump_valid_q;
  logic [DW-1:0] dump_data_q;
  logic          dump_layer_q;
  logic [AW-1:0] dump_addr_q;
  logic          dump_last_q;
  logic          done_q;

  logic dump_act, out_free, issue, iss_l1, iss_layer_end, iss_final, final_acc;

  // Bank writes; suppressed while reset is held so the array keeps its contents
  always_ff @(posedge clk) begin
    if (reset && cwr) begin
      if (csel == CSEL_L0) begin
        l0_mem[caddr_wr[L0AW-1:0]] <= cdata_wr;
      end else if (csel == CSEL_L1) begin
        l1_mem[caddr_wr[L1AW-1:0]] <= cdata_wr;
      end
    end
  end

  // CONV read port (old data on same-edge collision) and per-layer written flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cdata_rd_q <= '0;
      wr0_seen_q <= 1'b0;
      wr1_seen_q <= 1'b0;
    end else begin
      if (crd) begin
        if (csel == CSEL_L0) begin
          cdata_rd_q <= l0_mem[caddr_rd[L0AW-1:0]];
        end else if (csel == CSEL_L1) begin
          cdata_rd_q <= l1_mem[caddr_rd[L1AW-1:0]];
        end
      end
      if (cwr && (csel == CSEL_L0)) wr0_seen_q <= 1'b1;
      if (cwr && (csel == CSEL_L1)) wr1_seen_q <= 1'b1;
    end
  end

  // FSM state and issue-pointer registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      iss_addr_q <= '0;
      iss_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      iss_addr_q <= iss_addr_d;
      iss_done_q <= iss_done_d;
    end
  end

  // Dump issue decode: load a word whenever the output register is empty or being drained
  always_comb begin
    dump_act      = (state_q == StDump0) || (state_q == StDump1);
    out_free      = !dump_valid_q || dump_ready;
    issue         = dump_act && !iss_done_q && out_free;
    iss_l1        = (state_q == StDump1);
    iss_layer_end = iss_l1 ? (iss_addr_q == L1_LAST) : (iss_addr_q == L0_LAST);
    // Last of layer 0 is only the final word when layer 1 has nothing to contribute
    iss_final     = iss_layer_end && (iss_l1 || !wr1_seen_q);
    final_acc     = dump_valid_q && dump_ready && dump_last_q;
  end

  // Next-state: the issue side runs ahead into DUMP1; FIN waits for the last word to drain
  always_comb begin
    state_d    = state_q;
    iss_addr_d = iss_addr_q;
    iss_done_d = iss_done_q;
    unique case (state_q)
      StIdle: begin
        iss_addr_d = '0;
        iss_done_d = 1'b0;
        if (busy) state_d = StArmed;
      end
      StArmed: begin
        iss_addr_d = '0;
        iss_done_d = 1'b0;
        if (!busy) begin
          if (wr0_seen_q)      state_d = StDump0;
          else if (wr1_seen_q) state_d = StDump1;
          else                 state_d = StFin;
        end
      end
      StDump0, StDump1: begin
        if (issue) begin
          iss_addr_d = iss_layer_end ? '0 : iss_addr_q + AW'(1);
          if (iss_final) iss_done_d = 1'b1;
        end
        if ((state_q == StDump0) && issue && iss_layer_end && !iss_final) begin
          state_d = StDump1;
        end else if (final_acc) begin
          state_d = StFin;
        end
      end
      StFin: begin
        state_d = StFin;
      end
      default: state_d = StIdle;
    endcase
  end

  // Dump output register and sticky done flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dump_valid_q <= 1'b0;
      dump_data_q  <= '0;
      dump_layer_q <= 1'b0;
      dump_addr_q  <= '0;
      dump_last_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      if (issue) begin
        dump_valid_q <= 1'b1;
        dump_data_q  <= iss_l1 ? l1_mem[iss_addr_q[L1AW-1:0]] : l0_mem[iss_addr_q[L0AW-1:0]];
        dump_layer_q <= iss_l1;
        dump_addr_q  <= iss_addr_q;
        dump_last_q  <= iss_final;
      end else if (out_free) begin
        dump_valid_q <= 1'b0;
      end
      if (state_d == StFin) done_q <= 1'b1;
    end
  end

  assign cdata_rd   = cdata_rd_q;
  assign dump_valid = dump_valid_q;
  assign dump_data  = dump_data_q;
  assign dump_layer = dump_layer_q;
  assign dump_addr  = dump_addr_q;
  assign dump_last  = dump_last_q;
  assign done       = done_q;

endmodule

// File: tb/tb_conv_layer_mem.sv
// Directed bench for conv_layer_mem: CONV-side read/write, collisions, full, back-pressured,
// partial, empty and reset-interrupted dumps against an address-pattern model.
module tb_conv_layer_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic        busy;
  logic        cwr;
  logic [11:0] caddr_wr;
  logic [19:0] cdata_wr;
  logic        crd;
  logic [11:0] caddr_rd;
  logic [2:0]  csel;
  logic [19:0] cdata_rd;
  logic        dump_valid;
  logic        dump_ready;
  logic [19:0] dump_data;
  logic        dump_layer;
  logic [11:0] dump_addr;
  logic        dump_last;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  conv_layer_mem dut (
    .clk        (clk),
    .reset      (reset),
    .busy       (busy),
    .cwr        (cwr),
    .caddr_wr   (caddr_wr),
    .cdata_wr   (cdata_wr),
    .crd        (crd),
    .caddr_rd   (caddr_rd),
    .csel       (csel),
    .cdata_rd   (cdata_rd),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_data  (dump_data),
    .dump_layer (dump_layer),
    .dump_addr  (dump_addr),
    .dump_last  (dump_last),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] sel, input logic [11:0] a, input logic [19:0] d);
    cwr = 1'b1; csel = sel; caddr_wr = a; cdata_wr = d;
    tick();
    cwr = 1'b0;
  endtask

  task automatic rd(input logic [2:0] sel, input logic [11:0] a);
    crd = 1'b1; csel = sel; caddr_rd = a;
    tick();
    crd = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  // busy 0->1->0; returns just after the edge following which busy is low
  task automatic pulse_busy();
    busy = 1'b1;
    tick();
    tick();
    busy = 1'b0;
  endtask

  function automatic logic [63:0] exp_word(input int k, input bit has_l0, input int total);
    int j;
    logic lst;
    lst = (k == total - 1);
    if (has_l0 && k < 4096) begin
      return {30'd0, 1'b0, 12'(k), lst, 20'(k)};
    end
    j = has_l0 ? k - 4096 : k;
    return {30'd0, 1'b1, 12'(j), lst, 20'h80000 + 20'(j)};
  endfunction

  task automatic run_dump(input int total, input bit has_l0, input int pct, input int budget);
    int k;
    int cyc;
    bit last_acc;
    k = 0;
    cyc = 0;
    while (done !== 1'b1 && cyc < budget) begin
      dump_ready = ($urandom_range(99) < pct);
      last_acc = 1'b0;
      if (dump_valid === 1'b1) begin
        check_eq("dump_word", {30'd0, dump_layer, dump_addr, dump_last, dump_data},
                 exp_word(k, has_l0, total));
        if (dump_ready) begin
          k++;
          last_acc = (k == total);
        end
      end
      tick();
      cyc++;
      if (last_acc) begin
        check_eq("done_after_last", 64'(done), 64'd1);
        check_eq("valid_after_last", 64'(dump_valid), 64'd0);
      end
    end
    check_eq("dump_count", 64'(k), 64'(total));
    check_eq("dump_done", 64'(done), 64'd1);
    dump_ready = 1'b1;
  endtask

  initial begin
    reset = 1'b0; busy = 1'b0; cwr = 1'b0; crd = 1'b0; csel = 3'b000;
    caddr_wr = '0; cdata_wr = '0; caddr_rd = '0; dump_ready = 1'b1;
    #1;
    check_eq("rst_cdata_rd", 64'(cdata_rd), 64'd0);
    check_eq("rst_dump", {30'd0, dump_valid, dump_layer, dump_addr, dump_last, dump_data},
             64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    tick();
    reset = 1'b1;
    tick();

    // Contents survive reset; strobes under reset do nothing
    wr(3'b001, 12'd5, 20'h12345);
    reset = 1'b0;
    cwr = 1'b1; crd = 1'b1; csel = 3'b001; caddr_wr = 12'd5; cdata_wr = 20'hFFFFF;
    caddr_rd = 12'd5;
    tick();
    tick();
    check_eq("rst_hold_cdata_rd", 64'(cdata_rd), 64'd0);
    check_eq("rst_hold_valid", 64'(dump_valid), 64'd0);
    check_eq("rst_hold_done", 64'(done), 64'd0);
    cwr = 1'b0; crd = 1'b0;
    reset = 1'b1;
    tick();
    rd(3'b001, 12'd5);
    check_eq("l0_keep_after_rst", 64'(cdata_rd), 64'h12345);

    // Write / read-back latency
    wr(3'b001, 12'h123, 20'hABCDE);
    rd(3'b001, 12'h123);
    check_eq("l0_rd", 64'(cdata_rd), 64'hABCDE);
    wr(3'b011, 12'h3FF, 20'h00001);
    rd(3'b011, 12'h3FF);
    check_eq("l1_rd", 64'(cdata_rd), 64'h00001);
    wr(3'b011, 12'hC05, 20'h54321);
    rd(3'b011, 12'h005);
    check_eq("l1_alias_rd", 64'(cdata_rd), 64'h54321);
    rd(3'b011, 12'hFFF);
    check_eq("l1_alias_rd2", 64'(cdata_rd), 64'h00001);
    wr(3'b010, 12'h123, 20'h77777);
    rd(3'b010, 12'h123);
    check_eq("unmapped_rd_hold", 64'(cdata_rd), 64'h00001);
    rd(3'b001, 12'h123);
    check_eq("unmapped_wr_ignored", 64'(cdata_rd), 64'hABCDE);
    tick();
    check_eq("crd_low_hold", 64'(cdata_rd), 64'hABCDE);

    // Same-edge read/write to one address returns the old word
    wr(3'b001, 12'd7, 20'h11111);
    cwr = 1'b1; crd = 1'b1; csel = 3'b001; caddr_wr = 12'd7; caddr_rd = 12'd7;
    cdata_wr = 20'h22222;
    tick();
    cwr = 1'b0; crd = 1'b0;
    check_eq("collision_old", 64'(cdata_rd), 64'h11111);
    rd(3'b001, 12'd7);
    check_eq("collision_new", 64'(cdata_rd), 64'h22222);

    // Full dump with host always ready
    for (int i = 0; i < 4096; i++) wr(3'b001, 12'(i), 20'(i));
    for (int j = 0; j < 1024; j++) wr(3'b011, 12'(j), 20'h80000 + 20'(j));
    dump_ready = 1'b1;
    pulse_busy();
    tick();
    check_eq("first_valid_early", 64'(dump_valid), 64'd0);
    tick();
    check_eq("first_valid", 64'(dump_valid), 64'd1);
    run_dump(5120, 1'b1, 100, 6000);

    // Busy pulse after completion is ignored
    pulse_busy();
    repeat (4) tick();
    check_eq("fin_ignore_busy_valid", 64'(dump_valid), 64'd0);
    check_eq("fin_ignore_busy_done", 64'(done), 64'd1);

    // Back-pressured full dump
    do_reset();
    wr(3'b001, 12'd0, 20'd0);
    wr(3'b011, 12'd0, 20'h80000);
    pulse_busy();
    run_dump(5120, 1'b1, 50, 30000);

    // Only layer 1 written
    do_reset();
    wr(3'b011, 12'd0, 20'h80000);
    pulse_busy();
    run_dump(1024, 1'b0, 70, 4000);

    // Nothing written: done one cycle after the busy fall, no words
    do_reset();
    pulse_busy();
    check_eq("empty_done_early", 64'(done), 64'd0);
    tick();
    check_eq("empty_done", 64'(done), 64'd1);
    check_eq("empty_valid", 64'(dump_valid), 64'd0);

    // Reset in the middle of a dump
    do_reset();
    wr(3'b001, 12'd0, 20'd0);
    dump_ready = 1'b1;
    pulse_busy();
    repeat (102) tick();
    check_eq("mid_dump_addr", 64'(dump_addr), 64'd100);
    reset = 1'b0;
    #1;
    check_eq("mid_rst_dump", {30'd0, dump_valid, dump_layer, dump_addr, dump_last, dump_data},
             64'd0);
    check_eq("mid_rst_done", 64'(done), 64'd0);
    tick();
    reset = 1'b1;
    repeat (5) tick();
    check_eq("idle_after_rst", 64'(dump_valid), 64'd0);
    wr(3'b001, 12'd0, 20'd0);
    pulse_busy();
    tick();
    tick();
    check_eq("restart_valid", 64'(dump_valid), 64'd1);
    check_eq("restart_addr", 64'(dump_addr), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
